keypad_scan_encoder: RTL

Scan-side partner of the 12-key keypad multiplexer: drives the 4-bit key-select code into the mux, samples the mux's single data output, and turns the scanned key states into debounced, encoded key events. Sits between the keypad mux and the launchpad sound/light logic, which consumes one 4-bit key code per press through a valid/ready handshake.

---
 rtl/keypad_scan_encoder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_encoder.sv
// ============================================================================
// Module   : keypad_scan_encoder
// Purpose  : Scans a 12-key keypad multiplexer and produces debounced, encoded
//            key events over a valid/ready handshake. Optional auto-repeat is
//            enabled with the KEYPAD_REPEAT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan_encoder #(
    parameter int SCAN_DIV        = 8,
    parameter int DEBOUNCE_ROUNDS = 3,
    parameter int REPEAT_ROUNDS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] B_out,
    input  logic       D_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_HELD     = 2'd2;
    localparam logic [3:0] c_NONE     = 4'hF;
    localparam logic [3:0] c_LAST_IDX = 4'd11;

    if (SCAN_DIV < 4 || SCAN_DIV > 255) begin : g_bad_scan_div
        $error("SCAN_DIV out of range 4..255");
    end
    if (DEBOUNCE_ROUNDS < 1 || DEBOUNCE_ROUNDS > 15) begin : g_bad_debounce
        $error("DEBOUNCE_ROUNDS out of range 1..15");
    end
    if (REPEAT_ROUNDS < 1) begin : g_bad_repeat
        $error("REPEAT_ROUNDS must be at least 1");
    end

    logic       r_d_meta;
    logic       r_d_sync;
    logic [7:0] r_dwell;
    logic [3:0] r_idx;
    logic [3:0] r_acc_key;
    logic       r_acc_cand;
    logic       r_round_done;
    logic [3:0] r_round_key;
    logic       r_round_cand;
    logic [1:0] r_state;
    logic [3:0] r_cand;
    logic [3:0] r_cnt;
    logic [3:0] r_absent;
    logic [3:0] r_key_code;
    logic       r_key_valid;
    logic       r_overflow;

    logic       w_sample;
    logic [3:0] w_acc_key_nxt;
    logic       w_acc_cand_nxt;
    logic       w_emit;

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] r_rep;
`endif

    assign B_out     = r_idx;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == c_HELD);
    assign overflow  = r_overflow;

    assign w_sample       = (r_dwell == 8'(SCAN_DIV - 1));
    // First pressed index seen in the round wins, giving lowest-index priority.
    assign w_acc_key_nxt  = (r_acc_key == c_NONE && r_d_sync) ? r_idx : r_acc_key;
    assign w_acc_cand_nxt = r_acc_cand | (r_d_sync && (r_idx == r_cand));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_meta     <= 1'b0;
            r_d_sync     <= 1'b0;
            r_dwell      <= 8'd0;
            r_idx        <= 4'd0;
            r_acc_key    <= c_NONE;
            r_acc_cand   <= 1'b0;
            r_round_done <= 1'b0;
            r_round_key  <= c_NONE;
            r_round_cand <= 1'b0;
        end else begin
            r_d_meta     <= D_in;
            r_d_sync     <= r_d_meta;
            r_round_done <= 1'b0;
            if (w_sample) begin
                r_dwell <= 8'd0;
                if (r_idx == c_LAST_IDX) begin
                    r_idx        <= 4'd0;
                    r_round_done <= 1'b1;
                    r_round_key  <= w_acc_key_nxt;
                    r_round_cand <= w_acc_cand_nxt;
                    r_acc_key    <= c_NONE;
                    r_acc_cand   <= 1'b0;
                end else begin
                    r_idx      <= r_idx + 4'd1;
                    r_acc_key  <= w_acc_key_nxt;
                    r_acc_cand <= w_acc_cand_nxt;
                end
            end else begin
                r_dwell <= r_dwell + 8'd1;
            end
        end
    end

    always_comb begin
        w_emit = 1'b0;
        if (r_round_done) begin
            case (r_state)
                c_IDLE: begin
                    if (r_round_key != c_NONE && DEBOUNCE_ROUNDS == 1)
                        w_emit = 1'b1;
                end
                c_DEBOUNCE: begin
                    if (r_round_key == r_cand && (r_cnt + 4'd1) == 4'(DEBOUNCE_ROUNDS))
                        w_emit = 1'b1;
                end
                c_HELD: begin
`ifdef KEYPAD_REPEAT_EN
                    if (r_round_cand && (r_rep + 16'd1) == 16'(REPEAT_ROUNDS))
                        w_emit = 1'b1;
`endif
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cand   <= 4'd0;
            r_cnt    <= 4'd0;
            r_absent <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
            r_rep    <= 16'd0;
`endif
        end else if (r_round_done) begin
            case (r_state)
                c_IDLE: begin
                    if (r_round_key != c_NONE) begin
                        r_cand <= r_round_key;
                        if (DEBOUNCE_ROUNDS == 1) begin
                            r_state  <= c_HELD;
                            r_absent <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
                            r_rep    <= 16'd0;
`endif
                        end else begin
                            r_state <= c_DEBOUNCE;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                c_DEBOUNCE: begin
                    if (r_round_key == r_cand) begin
                        if ((r_cnt + 4'd1) == 4'(DEBOUNCE_ROUNDS)) begin
                            r_state  <= c_HELD;
                            r_cnt    <= 4'd0;
                            r_absent <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
                            r_rep    <= 16'd0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else if (r_round_key != c_NONE) begin
                        r_cand <= r_round_key;
                        r_cnt  <= 4'd1;
                    end else begin
                        r_state <= c_IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
                c_HELD: begin
                    // Presence is tracked per key, so a lower key cannot mask the held one.
                    if (r_round_cand) begin
                        r_absent <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
                        if ((r_rep + 16'd1) == 16'(REPEAT_ROUNDS))
                            r_rep <= 16'd0;
                        else
                            r_rep <= r_rep + 16'd1;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        r_rep <= 16'd0;
`endif
                        if ((r_absent + 4'd1) == 4'(DEBOUNCE_ROUNDS)) begin
                            r_state  <= c_IDLE;
                            r_absent <= 4'd0;
                        end else begin
                            r_absent <= r_absent + 4'd1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // An accept on the same edge as a new emit frees the slot, so no drop occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_emit) begin
            if (!r_key_valid || key_ready) begin
                r_key_code  <= (r_state == c_IDLE) ? r_round_key : r_cand;
                r_key_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (key_ready) begin
            r_key_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire
